// File: rtl/pwm_multichannel_if.sv
// Duty-write bus between the SPI register file (master) and pwm_multichannel (slave).
interface pwm_multichannel_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic             wr_en;
    logic [4:0]       wr_ch;
    logic [CNT_W-1:0] wr_duty;

    modport master (output wr_en, output wr_ch, output wr_duty);
    modport slave  (input  wr_en, input  wr_ch, input  wr_duty);
endinterface

// File: rtl/pwm_multichannel.sv
// N-channel PWM engine: shared prescaler and period counter, double-buffered per-channel duty.
// Define PWM_CENTER_ALIGN_EN for an up/down (center-aligned) counter instead of a sawtooth.
module pwm_multichannel #(
    parameter int unsigned NUM_CH  = 16,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned PRESC_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   en_out,
    input  logic [NUM_CH-1:0]   en_pwm,
    input  logic [PRESC_W-1:0]  prescale,
    pwm_multichannel_if.slave   wr,
    output logic [NUM_CH-1:0]   out,
    output logic                period_start
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   shadow_q [NUM_CH];
    logic [CNT_W-1:0]   shadow_d [NUM_CH];
    logic [CNT_W-1:0]   active_q [NUM_CH];
    logic [CNT_W-1:0]   active_d [NUM_CH];
    logic [NUM_CH-1:0]  out_q, out_d;
    logic               period_start_q, period_start_d;
    logic               tick;
    logic               boundary;

`ifdef PWM_CENTER_ALIGN_EN
    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
    dir_e dir_q, dir_d;
`endif

    // Prescaler and period counter; >= keeps the prescaler from stalling when prescale shrinks
    always_comb begin
        tick           = (presc_cnt_q >= prescale);
        presc_cnt_d    = tick ? '0 : presc_cnt_q + PRESC_W'(1);
        cnt_d          = cnt_q;
        boundary       = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
        dir_d          = dir_q;
        if (tick) begin
            case (dir_q)
                DIR_UP: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_d = CNT_MAX - CNT_W'(1);
                        dir_d = DIR_DOWN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        boundary = 1'b1;
                        dir_d    = DIR_UP;
                    end
                end
            endcase
        end
`else
        if (tick) begin
            cnt_d    = cnt_q + CNT_W'(1);
            boundary = (cnt_q == CNT_MAX);
        end
`endif
        period_start_d = boundary;
    end

    // Duty buffers and output mux; active loads the pre-write shadow on a coincident write
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        out_d    = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (boundary) begin
                active_d[i] = shadow_q[i];
            end
            if (wr.wr_en && (wr.wr_ch == 5'(i))) begin
                shadow_d[i] = wr.wr_duty;
            end
            out_d[i] = en_out[i] &
                       (~en_pwm[i] | (active_q[i] == CNT_MAX) | (cnt_q < active_q[i]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt_q    <= '0;
            cnt_q          <= '0;
            out_q          <= '0;
            period_start_q <= 1'b0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
`ifdef PWM_CENTER_ALIGN_EN
            dir_q          <= DIR_UP;
`endif
        end else begin
            presc_cnt_q    <= presc_cnt_d;
            cnt_q          <= cnt_d;
            out_q          <= out_d;
            period_start_q <= period_start_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
`ifdef PWM_CENTER_ALIGN_EN
            dir_q          <= dir_d;
`endif
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;
endmodule
